fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that owns the program counter, drives the address of the combinational instruction memory, and buffers fetched instructions in a small FIFO toward decode. It sits between the execute-stage redirect logic (branches and jumps) and the decode stage. It hides decode back-pressure from the memory, supplies each instruction with its PC, and flushes cleanly on control-flow redirects.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- QDEPTH, 2, fetch queue entries; power of two, 2..8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals the current PC register.
- imem_instr  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  32  target PC; sampled when redirect_valid=1.
- out_valid  out  1  queue head is valid for decode.
- out_ready  in  1  decode accepts the head.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- misaligned  out  1  sticky misaligned-redirect flag. Present only with FETCH_ALIGN_CHECK_EN; see Configuration.

## Operation
- State: the PC register, a circular queue of QDEPTH {pc, instr} entries with head pointer, tail pointer and count (0..QDEPTH), and the halt/misaligned flag when configured.
- pop = out_valid && out_ready.
- push = !redirect_valid && !halted && (count < QDEPTH || pop). The pushed entry is {PC, imem_instr}.
- On push: PC <= PC + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- No push: PC holds and imem_addr stays stable.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full queue with a pop in the same cycle: push and pop both occur and count stays QDEPTH.
- out_valid = (count != 0) && !redirect_valid. This is a combinational gate from redirect_valid, so no transfer to decode ever occurs in a redirect cycle.
- Redirect (priority over everything): count <= 0, both pointers <= 0, PC <= redirect_pc. Any head entry present is discarded.
- Empty queue: out_pc = 32'h0 and out_instr = 32'h0000_0013 (NOP).
- Non-empty queue: out_pc and out_instr are the head entry's fields.

## Timing
- Reset values: PC = RESET_PC, count = 0, out_valid = 0, out_pc = 0, out_instr = 32'h0000_0013, misaligned = 0. imem_addr = RESET_PC.
- Fetch-to-output latency is 1 cycle. The instruction fetched in cycle N is presented at decode in cycle N+1.
- First cycle after reset deasserts (cycle 0): imem_addr = RESET_PC. Cycle 1: out_valid = 1 with out_pc = RESET_PC.
- Redirect asserted in cycle N: imem_addr = redirect_pc in cycle N+1, and out_valid = 1 with out_pc = redirect_pc in cycle N+2.
- Sustained throughput is 1 instruction/cycle while out_ready stays high.
- Decode stall: the queue fills after QDEPTH cycles, then PC holds. When out_ready returns, there are no bubbles and no duplicate or lost entries.
- Reset mid-operation overrides redirects, pushes and pops in that cycle and restores all reset values.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 flushes as usual and loads PC.
  - It also sets misaligned = 1 and halted = 1 on the next edge.
  - While halted: no pushes and out_valid = 0.
  - A subsequent aligned redirect clears both flags and resumes fetch. Only reset or an aligned redirect clears them.
- FETCH_ALIGN_CHECK_EN undefined:
  - The misaligned port is absent.
  - redirect_pc[1:0] is ignored: PC loads {redirect_pc[31:2], 2'b00} and never halts.

## Test plan
- Reset with RESET_PC=0, out_ready=1, memory holding 0x00500093, 0x00a00113, 0x002081b3 -> cycles 1..3 present (pc 0, 0x00500093), (4, 0x00a00113), (8, 0x002081b3), one per cycle.
- QDEPTH=2, out_ready=0 for 5 cycles -> count=2, imem_addr holds at 8. Release out_ready -> pcs 0, 4, 8, 12 consecutive with no gap or repeat.
- Queue full and redirect_valid=1 to 0x40 with out_ready=1 -> out_valid=0 that cycle, count=0 next cycle, out_pc=0x40 two cycles after the redirect.
- Redirect to 0xFFFF_FFFC -> outputs pc 0xFFFF_FFFC, then 0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x42 -> misaligned=1 and out_valid=0 indefinitely. Then redirect to 0x80 -> misaligned=0 and out_pc=0x80 two cycles later. Without the macro, redirect to 0x42 -> out_pc=0x40.
- Assert reset while count=2 and a redirect is pending -> next cycle out_valid=0 and imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational imem and buffers {pc, instr} toward decode.
// Build option FETCH_ALIGN_CHECK_EN: misaligned redirects halt fetch and raise a sticky misaligned flag.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int          PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          CW   = $clog2(QDEPTH + 1);
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [31:0]   pc;
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          halted;
  logic          push;
  logic          pop;
  logic          empty;
  logic [31:0]   redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
  // The raw target is loaded even when misaligned; the halt keeps it from being fetched.
  assign redirect_target = redirect_pc;
  assign misaligned      = halted;

  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (redirect_valid) begin
      halted <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  logic unused_align;
  assign unused_align    = ^redirect_pc[1:0];
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign halted          = 1'b0;
`endif

  assign empty     = (count == '0);
  // Gated by redirect so nothing reaches decode in a flush cycle.
  assign out_valid = !empty && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && !halted && ((count != FULL) || pop);
  assign imem_addr = pc;
  assign out_pc    = empty ? 32'h0 : q_pc[head];
  assign out_instr = empty ? NOP   : q_instr[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_target;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc   <= pc + 32'd4;
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]    <= pc;
      q_instr[tail] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random redirect/stall/reset traffic against a queue model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: PC, FIFO of fetched PCs, halt flag.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_halt;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   memf = 32'h0050_0093;
      32'h4:   memf = 32'h00a0_0113;
      32'h8:   memf = 32'h0020_81b3;
      default: memf = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  assign imem_instr = memf(imem_addr);

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .misaligned     (misaligned),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_advance();
    bit pop;
    bit push;
    if (reset) begin
      m_q.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc   = redirect_pc;
      m_halt = (redirect_pc % 4) != 0;
`else
      m_pc   = redirect_pc - (redirect_pc % 4);
`endif
    end else begin
      pop  = (m_q.size() != 0) && out_ready;
      push = !m_halt && ((m_q.size() < QDEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic compare();
    bit has = (m_q.size() != 0);
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, has && !redirect_valid});
    chk("out_pc", out_pc, has ? m_q[0] : 32'h0);
    chk("out_instr", out_instr, has ? memf(m_q[0]) : 32'h0000_0013);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_halt});
`endif
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    model_advance();
    @(posedge clk);
    #1;
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    // Reset values and first three fetches at one per cycle.
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c0_addr", imem_addr, RESET_PC);
    chk("c0_valid", {31'b0, out_valid}, 32'h0);
    chk("c0_pc", out_pc, 32'h0);
    chk("c0_instr", out_instr, 32'h0000_0013);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c1_valid", {31'b0, out_valid}, 32'h1);
    chk("c1_pc", out_pc, 32'h0);
    chk("c1_instr", out_instr, 32'h0050_0093);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c2_pc", out_pc, 32'h4);
    chk("c2_instr", out_instr, 32'h00a0_0113);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c3_pc", out_pc, 32'h8);
    chk("c3_instr", out_instr, 32'h0020_81b3);

    // Decode stall fills the queue and freezes the PC; release drains without gaps.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_pc", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk("drain_valid", {31'b0, out_valid}, 32'h1);
      chk("drain_pc", out_pc, 32'(4 * i));
    end

    // Redirect while full.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    chk("rd_flush_valid", {31'b0, out_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_n1_valid", {31'b0, out_valid}, 32'h0);
    chk("rd_n1_addr", imem_addr, 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_n2_valid", {31'b0, out_valid}, 32'h1);
    chk("rd_n2_pc", out_pc, 32'h40);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc1", out_pc, 32'h0);

    // Misaligned redirect.
    step(1'b0, 1'b1, 32'h42, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk("mis_flag", {31'b0, misaligned}, 32'h1);
      chk("mis_valid", {31'b0, out_valid}, 32'h0);
    end
    step(1'b0, 1'b1, 32'h80, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mis_clear", {31'b0, misaligned}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mis_resume_pc", out_pc, 32'h80);
    chk("mis_resume_valid", {31'b0, out_valid}, 32'h1);
`else
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("align_pc", out_pc, 32'h40);
    chk("align_valid", {31'b0, out_valid}, 32'h1);
`endif

    // Reset beats a pending redirect with a full queue.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h100, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step(r, rv, rpc, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
